// File: rtl/brdg_axi_slave_cmd_sched.sv
// Read/write command scheduler: pops FWFT AW/AR command FIFOs, round-robins between them,
// gates writes on buffered data and outstanding limits, and drives one registered command stream.
module brdg_axi_slave_cmd_sched #(
    parameter int IDW    = 5,
    parameter int CTXW   = 9,
    parameter int MAX_RD = 32,
    parameter int MAX_WR = 32,
    parameter int CNTW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_cf_empty,
    input  logic [IDW-1:0]  wr_cf_id,
    input  logic [63:0]     wr_cf_addr,
    input  logic [7:0]      wr_cf_len,
    input  logic [2:0]      wr_cf_size,
    input  logic [1:0]      wr_cf_burst,
    input  logic [CTXW-1:0] wr_cf_user,
    output logic            wr_cf_rd_en,
    input  logic            rd_cf_empty,
    input  logic [IDW-1:0]  rd_cf_id,
    input  logic [63:0]     rd_cf_addr,
    input  logic [7:0]      rd_cf_len,
    input  logic [2:0]      rd_cf_size,
    input  logic [1:0]      rd_cf_burst,
    input  logic [CTXW-1:0] rd_cf_user,
    output logic            rd_cf_rd_en,
    input  logic            wr_data_ok,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic            cmd_is_wr,
    output logic [IDW-1:0]  cmd_id,
    output logic [63:0]     cmd_addr,
    output logic [7:0]      cmd_len,
    output logic [2:0]      cmd_size,
    output logic [1:0]      cmd_burst,
    output logic [CTXW-1:0] cmd_user,
    input  logic            rd_done,
    input  logic            wr_done,
    output logic [CNTW-1:0] rd_outstanding,
    output logic [CNTW-1:0] wr_outstanding,
    output logic            cnt_err
);

    localparam logic [CNTW-1:0] MAX_RD_C = CNTW'(MAX_RD);
    localparam logic [CNTW-1:0] MAX_WR_C = CNTW'(MAX_WR);
    localparam logic [CNTW-1:0] ONE      = CNTW'(1);

    logic            last_grant_wr;
    logic            slot_free;
    logic            rd_elig;
    logic            wr_elig;
    logic            grant_rd;
    logic            grant_wr;
    logic [CNTW-1:0] rd_cnt_nxt;
    logic [CNTW-1:0] wr_cnt_nxt;
    logic            err_nxt;

    assign slot_free = !cmd_valid || cmd_ready;
    assign rd_elig   = !rd_cf_empty && (rd_outstanding < MAX_RD_C);
    assign wr_elig   = !wr_cf_empty && wr_data_ok && (wr_outstanding < MAX_WR_C);

    // On a tie the side that did not win last time gets the slot.
    assign grant_rd = slot_free && rd_elig && (!wr_elig || last_grant_wr);
    assign grant_wr = slot_free && wr_elig && (!rd_elig || !last_grant_wr);

    assign rd_cf_rd_en = grant_rd && !rst;
    assign wr_cf_rd_en = grant_wr && !rst;

    always_comb begin
        rd_cnt_nxt = rd_outstanding;
        wr_cnt_nxt = wr_outstanding;
        err_nxt    = cnt_err;
        if (grant_rd && !rd_done) begin
            rd_cnt_nxt = rd_outstanding + ONE;
        end else if (!grant_rd && rd_done) begin
            if (rd_outstanding == '0) err_nxt = 1'b1;
            else                      rd_cnt_nxt = rd_outstanding - ONE;
        end
        if (grant_wr && !wr_done) begin
            wr_cnt_nxt = wr_outstanding + ONE;
        end else if (!grant_wr && wr_done) begin
            if (wr_outstanding == '0) err_nxt = 1'b1;
            else                      wr_cnt_nxt = wr_outstanding - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid      <= 1'b0;
            cmd_is_wr      <= 1'b0;
            cmd_id         <= '0;
            cmd_addr       <= '0;
            cmd_len        <= '0;
            cmd_size       <= '0;
            cmd_burst      <= '0;
            cmd_user       <= '0;
            last_grant_wr  <= 1'b1;
            rd_outstanding <= '0;
            wr_outstanding <= '0;
            cnt_err        <= 1'b0;
        end else begin
            if (slot_free) cmd_valid <= grant_rd || grant_wr;
            if (grant_rd) begin
                cmd_is_wr     <= 1'b0;
                cmd_id        <= rd_cf_id;
                cmd_addr      <= rd_cf_addr;
                cmd_len       <= rd_cf_len;
                cmd_size      <= rd_cf_size;
                cmd_burst     <= rd_cf_burst;
                cmd_user      <= rd_cf_user;
                last_grant_wr <= 1'b0;
            end else if (grant_wr) begin
                cmd_is_wr     <= 1'b1;
                cmd_id        <= wr_cf_id;
                cmd_addr      <= wr_cf_addr;
                cmd_len       <= wr_cf_len;
                cmd_size      <= wr_cf_size;
                cmd_burst     <= wr_cf_burst;
                cmd_user      <= wr_cf_user;
                last_grant_wr <= 1'b1;
            end
            rd_outstanding <= rd_cnt_nxt;
            wr_outstanding <= wr_cnt_nxt;
            cnt_err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_brdg_axi_slave_cmd_sched.sv
// Directed bench for the command scheduler; a second instance with limits of 2 covers the outstanding cap.
module tb_brdg_axi_slave_cmd_sched;

    localparam logic [4:0]  RD_ID = 5'h0A, WR_ID = 5'h15;
    localparam logic [63:0] RD_ADDR = 64'h0000_1111_2222_3330, WR_ADDR = 64'hFFFF_0000_ABCD_0040;
    localparam logic [63:0] ALT_ADDR = 64'h5555_6666_7777_8880;
    localparam logic [7:0]  RD_LEN = 8'h0F, WR_LEN = 8'h03;
    localparam logic [2:0]  RD_SIZE = 3'd3, WR_SIZE = 3'd2;
    localparam logic [1:0]  RD_BURST = 2'd1, WR_BURST = 2'd2;
    localparam logic [8:0]  RD_USER = 9'h1A5, WR_USER = 9'h05A;

    logic clk = 1'b0;
    logic rst;
    logic wr_cf_empty, rd_cf_empty, wr_data_ok, cmd_ready, rd_done, wr_done;
    logic [4:0]  wr_cf_id, rd_cf_id;
    logic [63:0] wr_cf_addr, rd_cf_addr;
    logic [7:0]  wr_cf_len, rd_cf_len;
    logic [2:0]  wr_cf_size, rd_cf_size;
    logic [1:0]  wr_cf_burst, rd_cf_burst;
    logic [8:0]  wr_cf_user, rd_cf_user;

    logic        wr_cf_rd_en, rd_cf_rd_en, cmd_valid, cmd_is_wr, cnt_err;
    logic [4:0]  cmd_id;
    logic [63:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [8:0]  cmd_user;
    logic [5:0]  rd_outstanding, wr_outstanding;

    logic        lim_wr_en, lim_rd_en, lim_valid, lim_is_wr, lim_err;
    logic [4:0]  lim_id;
    logic [63:0] lim_addr;
    logic [7:0]  lim_len;
    logic [2:0]  lim_size;
    logic [1:0]  lim_burst;
    logic [8:0]  lim_user;
    logic [5:0]  lim_rd_out, lim_wr_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    brdg_axi_slave_cmd_sched dut (
        .clk(clk), .rst(rst),
        .wr_cf_empty(wr_cf_empty), .wr_cf_id(wr_cf_id), .wr_cf_addr(wr_cf_addr), .wr_cf_len(wr_cf_len),
        .wr_cf_size(wr_cf_size), .wr_cf_burst(wr_cf_burst), .wr_cf_user(wr_cf_user), .wr_cf_rd_en(wr_cf_rd_en),
        .rd_cf_empty(rd_cf_empty), .rd_cf_id(rd_cf_id), .rd_cf_addr(rd_cf_addr), .rd_cf_len(rd_cf_len),
        .rd_cf_size(rd_cf_size), .rd_cf_burst(rd_cf_burst), .rd_cf_user(rd_cf_user), .rd_cf_rd_en(rd_cf_rd_en),
        .wr_data_ok(wr_data_ok), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .cmd_user(cmd_user), .rd_done(rd_done), .wr_done(wr_done), .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding), .cnt_err(cnt_err)
    );

    brdg_axi_slave_cmd_sched #(.MAX_RD(2), .MAX_WR(2)) dut_lim (
        .clk(clk), .rst(rst),
        .wr_cf_empty(wr_cf_empty), .wr_cf_id(wr_cf_id), .wr_cf_addr(wr_cf_addr), .wr_cf_len(wr_cf_len),
        .wr_cf_size(wr_cf_size), .wr_cf_burst(wr_cf_burst), .wr_cf_user(wr_cf_user), .wr_cf_rd_en(lim_wr_en),
        .rd_cf_empty(rd_cf_empty), .rd_cf_id(rd_cf_id), .rd_cf_addr(rd_cf_addr), .rd_cf_len(rd_cf_len),
        .rd_cf_size(rd_cf_size), .rd_cf_burst(rd_cf_burst), .rd_cf_user(rd_cf_user), .rd_cf_rd_en(lim_rd_en),
        .wr_data_ok(wr_data_ok), .cmd_valid(lim_valid), .cmd_ready(cmd_ready), .cmd_is_wr(lim_is_wr),
        .cmd_id(lim_id), .cmd_addr(lim_addr), .cmd_len(lim_len), .cmd_size(lim_size), .cmd_burst(lim_burst),
        .cmd_user(lim_user), .rd_done(rd_done), .wr_done(wr_done), .rd_outstanding(lim_rd_out),
        .wr_outstanding(lim_wr_out), .cnt_err(lim_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        rd_cf_empty = 1'b1; wr_cf_empty = 1'b1; wr_data_ok = 1'b0;
        cmd_ready = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
        rd_cf_addr = RD_ADDR;
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_cf_empty = 1'b0; wr_cf_empty = 1'b0; wr_data_ok = 1'b1; cmd_ready = 1'b1;
        rd_done = 1'b0; wr_done = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({cmd_valid, cmd_is_wr, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_user} !== '0) begin
            n_err++; $display("FAIL reset_cmd: valid=%b is_wr=%b addr=%h required all zero", cmd_valid, cmd_is_wr, cmd_addr);
        end
        n_cmp++;
        if ({rd_outstanding, wr_outstanding, cnt_err} !== '0) begin
            n_err++; $display("FAIL reset_cnt: rd=%0d wr=%0d err=%b required 0/0/0", rd_outstanding, wr_outstanding, cnt_err);
        end
        n_cmp++;
        if ({rd_cf_rd_en, wr_cf_rd_en} !== 2'b00) begin
            n_err++; $display("FAIL reset_pop: rd_en=%b wr_en=%b required 0/0", rd_cf_rd_en, wr_cf_rd_en);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_round_robin;
        int e_rden[4]  = '{1, 0, 1, 0};
        int e_iswr[4]  = '{0, 1, 0, 1};
        int e_rdcnt[4] = '{1, 1, 2, 2};
        int e_wrcnt[4] = '{0, 1, 1, 2};
        reset_dut;
        rd_cf_empty = 1'b0; wr_cf_empty = 1'b0; wr_data_ok = 1'b1; cmd_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_cf_rd_en !== 1'(e_rden[i]) || wr_cf_rd_en !== !1'(e_rden[i])) begin
                n_err++; $display("FAIL rr_pop[%0d]: rd_en=%b wr_en=%b required rd_en=%0d", i, rd_cf_rd_en, wr_cf_rd_en, e_rden[i]);
            end
            tick;
            n_cmp++;
            if (cmd_valid !== 1'b1 || cmd_is_wr !== 1'(e_iswr[i])) begin
                n_err++; $display("FAIL rr_cmd[%0d]: valid=%b is_wr=%b required 1/%0d", i, cmd_valid, cmd_is_wr, e_iswr[i]);
            end
            n_cmp++;
            if (rd_outstanding !== 6'(e_rdcnt[i]) || wr_outstanding !== 6'(e_wrcnt[i])) begin
                n_err++; $display("FAIL rr_cnt[%0d]: rd=%0d wr=%0d required %0d/%0d", i, rd_outstanding, wr_outstanding, e_rdcnt[i], e_wrcnt[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if ({cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_user} !== {RD_ID, RD_ADDR, RD_LEN, RD_SIZE, RD_BURST, RD_USER}) begin
                    n_err++; $display("FAIL rr_rd_fields: id=%h addr=%h len=%h required id=%h addr=%h len=%h", cmd_id, cmd_addr, cmd_len, RD_ID, RD_ADDR, RD_LEN);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if ({cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_user} !== {WR_ID, WR_ADDR, WR_LEN, WR_SIZE, WR_BURST, WR_USER}) begin
                    n_err++; $display("FAIL rr_wr_fields: id=%h addr=%h len=%h required id=%h addr=%h len=%h", cmd_id, cmd_addr, cmd_len, WR_ID, WR_ADDR, WR_LEN);
                end
            end
        end
        rd_cf_empty = 1'b1; wr_cf_empty = 1'b1;
        tick;
        n_cmp++;
        if (cmd_valid !== 1'b0 || cmd_is_wr !== 1'b1 || cmd_addr !== WR_ADDR) begin
            n_err++; $display("FAIL rr_drain: valid=%b is_wr=%b addr=%h required 0/1/%h", cmd_valid, cmd_is_wr, cmd_addr, WR_ADDR);
        end
    endtask

    task automatic test_wr_data_gate;
        reset_dut;
        wr_cf_empty = 1'b0; wr_data_ok = 1'b0; rd_cf_empty = 1'b0; cmd_ready = 1'b1;
        #1;
        n_cmp++;
        if (rd_cf_rd_en !== 1'b1 || wr_cf_rd_en !== 1'b0) begin
            n_err++; $display("FAIL gate_rd_passes: rd_en=%b wr_en=%b required 1/0", rd_cf_rd_en, wr_cf_rd_en);
        end
        tick;
        rd_cf_empty = 1'b1;
        #1;
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_is_wr !== 1'b0 || wr_cf_rd_en !== 1'b0) begin
            n_err++; $display("FAIL gate_rd_cmd: valid=%b is_wr=%b wr_en=%b required 1/0/0", cmd_valid, cmd_is_wr, wr_cf_rd_en);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++;
            if (cmd_valid !== 1'b0 || wr_cf_rd_en !== 1'b0) begin
                n_err++; $display("FAIL gate_hold[%0d]: valid=%b wr_en=%b required 0/0", i, cmd_valid, wr_cf_rd_en);
            end
        end
        wr_data_ok = 1'b1;
        #1;
        n_cmp++;
        if (wr_cf_rd_en !== 1'b1) begin
            n_err++; $display("FAIL gate_release_pop: wr_en=%b required 1", wr_cf_rd_en);
        end
        tick;
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_is_wr !== 1'b1 || wr_outstanding !== 6'd1) begin
            n_err++; $display("FAIL gate_release_cmd: valid=%b is_wr=%b wr=%0d required 1/1/1", cmd_valid, cmd_is_wr, wr_outstanding);
        end
    endtask

    task automatic test_backpressure;
        reset_dut;
        rd_cf_empty = 1'b0; wr_cf_empty = 1'b0; wr_data_ok = 1'b1; cmd_ready = 1'b0;
        #1;
        n_cmp++;
        if (rd_cf_rd_en !== 1'b1) begin
            n_err++; $display("FAIL bp_first_pop: rd_en=%b required 1", rd_cf_rd_en);
        end
        tick;
        rd_cf_addr = ALT_ADDR;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (cmd_valid !== 1'b1 || cmd_is_wr !== 1'b0 || cmd_addr !== RD_ADDR || rd_cf_rd_en !== 1'b0 || wr_cf_rd_en !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: valid=%b is_wr=%b addr=%h pops=%b%b required 1/0/%h/00", i, cmd_valid, cmd_is_wr, cmd_addr, RD_ADDR, rd_cf_rd_en, wr_cf_rd_en);
            end
            tick;
        end
        n_cmp++;
        if (rd_outstanding !== 6'd1 || wr_outstanding !== 6'd0) begin
            n_err++; $display("FAIL bp_cnt: rd=%0d wr=%0d required 1/0", rd_outstanding, wr_outstanding);
        end
        cmd_ready = 1'b1;
        #1;
        n_cmp++;
        if (wr_cf_rd_en !== 1'b1 || rd_cf_rd_en !== 1'b0) begin
            n_err++; $display("FAIL bp_release_pop: rd_en=%b wr_en=%b required 0/1", rd_cf_rd_en, wr_cf_rd_en);
        end
        tick;
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_is_wr !== 1'b1 || cmd_addr !== WR_ADDR || wr_outstanding !== 6'd1) begin
            n_err++; $display("FAIL bp_release_cmd: valid=%b is_wr=%b addr=%h wr=%0d required 1/1/%h/1", cmd_valid, cmd_is_wr, cmd_addr, wr_outstanding, WR_ADDR);
        end
        rd_cf_addr = RD_ADDR;
    endtask

    task automatic test_rd_limit;
        reset_dut;
        rd_cf_empty = 1'b0; wr_cf_empty = 1'b1; cmd_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (lim_rd_en !== (i < 2)) begin
                n_err++; $display("FAIL lim_pop[%0d]: rd_en=%b required %b", i, lim_rd_en, (i < 2));
            end
            tick;
        end
        n_cmp++;
        if (lim_rd_out !== 6'd2) begin
            n_err++; $display("FAIL lim_cnt_full: rd=%0d required 2", lim_rd_out);
        end
        rd_done = 1'b1;
        #1;
        n_cmp++;
        if (lim_rd_en !== 1'b0) begin
            n_err++; $display("FAIL lim_done_cycle: rd_en=%b required 0", lim_rd_en);
        end
        tick;
        rd_done = 1'b0;
        #1;
        n_cmp++;
        if (lim_rd_out !== 6'd1 || lim_rd_en !== 1'b1) begin
            n_err++; $display("FAIL lim_after_done: rd=%0d rd_en=%b required 1/1", lim_rd_out, lim_rd_en);
        end
        tick;
        n_cmp++;
        if (lim_rd_out !== 6'd2 || lim_rd_en !== 1'b0 || lim_err !== 1'b0) begin
            n_err++; $display("FAIL lim_refill: rd=%0d rd_en=%b err=%b required 2/0/0", lim_rd_out, lim_rd_en, lim_err);
        end
    endtask

    task automatic test_done_counts;
        reset_dut;
        rd_cf_empty = 1'b0; cmd_ready = 1'b1;
        tick;
        n_cmp++;
        if (rd_outstanding !== 6'd1) begin
            n_err++; $display("FAIL done_first: rd=%0d required 1", rd_outstanding);
        end
        rd_done = 1'b1;
        #1;
        n_cmp++;
        if (rd_cf_rd_en !== 1'b1) begin
            n_err++; $display("FAIL done_same_pop: rd_en=%b required 1", rd_cf_rd_en);
        end
        tick;
        rd_done = 1'b0; rd_cf_empty = 1'b1;
        n_cmp++;
        if (rd_outstanding !== 6'd1) begin
            n_err++; $display("FAIL done_same_cycle: rd=%0d required 1", rd_outstanding);
        end
        tick;
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
        n_cmp++;
        if (rd_outstanding !== 6'd0 || cnt_err !== 1'b0) begin
            n_err++; $display("FAIL done_to_zero: rd=%0d err=%b required 0/0", rd_outstanding, cnt_err);
        end
        wr_done = 1'b1;
        tick;
        wr_done = 1'b0;
        n_cmp++;
        if (wr_outstanding !== 6'd0 || cnt_err !== 1'b1) begin
            n_err++; $display("FAIL done_underflow: wr=%0d err=%b required 0/1", wr_outstanding, cnt_err);
        end
        tick;
        tick;
        n_cmp++;
        if (cnt_err !== 1'b1) begin
            n_err++; $display("FAIL done_err_sticky: err=%b required 1", cnt_err);
        end
    endtask

    task automatic test_reset_midop;
        reset_dut;
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
        n_cmp++;
        if (cnt_err !== 1'b1) begin
            n_err++; $display("FAIL mid_err_set: err=%b required 1", cnt_err);
        end
        rd_cf_empty = 1'b0; wr_cf_empty = 1'b0; wr_data_ok = 1'b1; cmd_ready = 1'b1;
        repeat (6) tick;
        rd_cf_empty = 1'b1;
        tick;
        cmd_ready = 1'b0;
        n_cmp++;
        if (rd_outstanding !== 6'd3 || wr_outstanding !== 6'd4 || cmd_valid !== 1'b1 || cmd_is_wr !== 1'b1) begin
            n_err++; $display("FAIL mid_state: rd=%0d wr=%0d valid=%b is_wr=%b required 3/4/1/1", rd_outstanding, wr_outstanding, cmd_valid, cmd_is_wr);
        end
        rst = 1'b1; rd_cf_empty = 1'b0; cmd_ready = 1'b1;
        #1;
        n_cmp++;
        if (rd_cf_rd_en !== 1'b0 || wr_cf_rd_en !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_pop: rd_en=%b wr_en=%b required 0/0", rd_cf_rd_en, wr_cf_rd_en);
        end
        tick;
        n_cmp++;
        if (cmd_valid !== 1'b0 || rd_outstanding !== 6'd0 || wr_outstanding !== 6'd0 || cnt_err !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_state: valid=%b rd=%0d wr=%0d err=%b required 0/0/0/0", cmd_valid, rd_outstanding, wr_outstanding, cnt_err);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rd_cf_rd_en !== 1'b1 || wr_cf_rd_en !== 1'b0) begin
            n_err++; $display("FAIL mid_first_tie: rd_en=%b wr_en=%b required 1/0", rd_cf_rd_en, wr_cf_rd_en);
        end
        tick;
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_is_wr !== 1'b0 || rd_outstanding !== 6'd1) begin
            n_err++; $display("FAIL mid_first_cmd: valid=%b is_wr=%b rd=%0d required 1/0/1", cmd_valid, cmd_is_wr, rd_outstanding);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_cf_empty = 1'b1; wr_cf_empty = 1'b1; wr_data_ok = 1'b0;
        cmd_ready = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
        rd_cf_id = RD_ID; rd_cf_addr = RD_ADDR; rd_cf_len = RD_LEN;
        rd_cf_size = RD_SIZE; rd_cf_burst = RD_BURST; rd_cf_user = RD_USER;
        wr_cf_id = WR_ID; wr_cf_addr = WR_ADDR; wr_cf_len = WR_LEN;
        wr_cf_size = WR_SIZE; wr_cf_burst = WR_BURST; wr_cf_user = WR_USER;
        test_reset;
        test_round_robin;
        test_wr_data_gate;
        test_backpressure;
        test_rd_limit;
        test_done_counts;
        test_reset_midop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
